// File: rtl/wb_bram_resp.sv
// Wishbone responder in front of a synchronous 2^adr_width x 32-bit block RAM.
// Define WB_BRAM_RESP_BURST_EN to support incrementing (CTI 3'b010) bursts at one beat per clock.
module wb_bram_resp #(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic [2:0]  wb_cti_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               state;
    logic                 ack_q;
    logic [adr_width-1:0] addr_q;
    logic [adr_width-1:0] rd_addr;
    logic                 rd_en;
    logic                 wr_en;
    logic                 req;
    logic [31:0]          rd_data;
    logic [31:0]          mem [0:(2**adr_width)-1];

    // Bits outside the word index are decoded upstream and deliberately dropped here.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

    assign req      = wb_cyc_i & wb_stb_i;
    assign wb_ack_o = ack_q & req;
    assign wb_dat_o = rd_data;
    assign wr_en    = ack_q & req & wb_we_i;

`ifdef WB_BRAM_RESP_BURST_EN
    localparam logic [adr_width-1:0] addr_inc = {{(adr_width-1){1'b0}}, 1'b1};

    logic burst_step;
    assign burst_step = ack_q & req & (wb_cti_i == 3'b010);
`else
    logic unused_cti;
    assign unused_cti = ^wb_cti_i;
`endif

    // Read port: the request address when idle, the following word while a burst advances.
    always_comb begin
        rd_addr = wb_adr_i[adr_width+1:2];
        rd_en   = (state == IDLE) & req & ~wb_we_i;
`ifdef WB_BRAM_RESP_BURST_EN
        if (state == XFER) begin
            rd_addr = addr_q + addr_inc;
            rd_en   = burst_step & ~wb_we_i;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            addr_q <= '0;
        end else if (state == IDLE) begin
            if (req) begin
                addr_q <= wb_adr_i[adr_width+1:2];
                state  <= XFER;
                ack_q  <= 1'b1;
            end
        end else begin
`ifdef WB_BRAM_RESP_BURST_EN
            if (burst_step) begin
                addr_q <= addr_q + addr_inc;
            end else begin
                state <= IDLE;
                ack_q <= 1'b0;
            end
`else
            state <= IDLE;
            ack_q <= 1'b0;
`endif
        end
    end

    // RAM array carries no reset; ack_q gating keeps writes off while reset is held.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[addr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_wb_bram_resp.sv
// Self-checking bench for wb_bram_resp: a word-array memory model plus directed Wishbone accesses.
// Expected burst timing follows WB_BRAM_RESP_BURST_EN when it is defined for the build.
module tb_wb_bram_resp;

    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef WB_BRAM_RESP_BURST_EN
    localparam int   NEXT_WAIT = 0;
    localparam logic BURST_ACK = 1'b1;
`else
    localparam int   NEXT_WAIT = 1;
    localparam logic BURST_ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;

    int          n_compared = 0;
    int          n_mismatch = 0;
    int          cur_word = 0;
    int          cur_beat = 0;
    logic [31:0] model_mem [0:DEPTH-1];
    logic [31:0] wr_buf [0:7];
    logic [31:0] rd_buf [0:7];
    int          wait_buf [0:7];

    wb_bram_resp #(.adr_width(AW)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel),
        .wb_cti_i (cti),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_ack_o (ack)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every acked beat: reads must match the model, writes update it lane by lane.
    always @(negedge clk) begin
        if (rst_n && ack) begin
            check_output("ack_needs_req", {31'b0, cyc & stb}, 32'h1);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) model_mem[cur_word][8*i +: 8] = dat_i[8*i +: 8];
                end
            end else begin
                check_output("read_data", dat_o, model_mem[cur_word]);
                rd_buf[cur_beat] = dat_o;
            end
        end
    end

    task automatic wait_ack(output int waited, output bit ok);
        waited = 0;
        @(negedge clk);
        while (!ack && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        ok = ack;
        if (!ok) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL ack_timeout: no ack after %0d cycles, expected an ack", waited);
        end
    endtask

    task automatic go_idle();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
    endtask

    // Master side: classic when beats==1, otherwise CTI 010...111 with the address stepping by 4.
    task automatic apply_stimulus(input logic [31:0] base, input int beats, input bit write,
                                  input bit hold_extra, input int abort_after);
        int waited;
        bit ok;
        bit stopped;
        stopped = 1'b0;
        for (int b = 0; b < beats && !stopped; b++) begin
            @(posedge clk);
            #1;
            adr      = base + 32'(4 * b);
            cur_word = int'(((base >> 2) + 32'(b)) % 32'(DEPTH));
            cur_beat = b;
            cti      = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
            dat_i    = wr_buf[b];
            we       = write;
            cyc      = 1'b1;
            stb      = 1'b1;
            if (b == abort_after) begin
                #1 check_output("abort_ack_before_drop", {31'b0, ack}, {31'b0, BURST_ACK});
                #1 stb = 1'b0;
                #1 check_output("abort_ack_same_cycle", {31'b0, ack}, 32'h0);
                stopped = 1'b1;
            end else begin
                wait_ack(waited, ok);
                wait_buf[b] = ok ? waited : 99;
                if (!ok) stopped = 1'b1;
            end
        end
        if (hold_extra && !stopped) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_output("ack_single_cycle", {31'b0, ack}, 32'h0);
        end
        @(posedge clk);
        #1 go_idle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        adr = 32'h0; dat_i = 32'h0; sel = 4'hF; cti = 3'b000;
        we = 1'b0; cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_buf[i] = 32'h0;
            wr_buf[i] = 32'h0;
            wait_buf[i] = 0;
        end

        #23;
        check_output("reset_ack", {31'b0, ack}, 32'h0);
        check_output("reset_dat", dat_o, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] classic write then read");
        sel = 4'hF; wr_buf[0] = 32'hDEADBEEF;
        apply_stimulus(32'h10, 1, 1'b1, 1'b0, -1);
        check_output("classic_wr_wait", 32'(wait_buf[0]), 32'd1);
        apply_stimulus(32'h10, 1, 1'b0, 1'b1, -1);
        check_output("classic_rd_wait", 32'(wait_buf[0]), 32'd1);
        check_output("classic_rd_value", rd_buf[0], 32'hDEADBEEF);

        $display("[TB] byte lanes");
        wr_buf[0] = 32'h11223344; sel = 4'hF;
        apply_stimulus(32'h20, 1, 1'b1, 1'b0, -1);
        wr_buf[0] = 32'hAABBCCDD; sel = 4'b0101;
        apply_stimulus(32'h20, 1, 1'b1, 1'b0, -1);
        sel = 4'hF;
        apply_stimulus(32'h20, 1, 1'b0, 1'b0, -1);
        check_output("lanes_value", rd_buf[0], 32'h11BB33DD);

        $display("[TB] four-beat bursts");
        for (int i = 0; i < 4; i++) wr_buf[i] = 32'(i + 1);
        apply_stimulus(32'h40, 4, 1'b1, 1'b0, -1);
        check_output("burst_wr_wait_1", 32'(wait_buf[1]), 32'(NEXT_WAIT));
        apply_stimulus(32'h40, 4, 1'b0, 1'b1, -1);
        check_output("burst_rd_wait_0", 32'(wait_buf[0]), 32'd1);
        for (int i = 1; i < 4; i++) check_output("burst_rd_wait_n", 32'(wait_buf[i]), 32'(NEXT_WAIT));
        check_output("burst_rd_0", rd_buf[0], 32'd1);
        check_output("burst_rd_1", rd_buf[1], 32'd2);
        check_output("burst_rd_2", rd_buf[2], 32'd3);
        check_output("burst_rd_3", rd_buf[3], 32'd4);

        $display("[TB] burst address wrap");
        wr_buf[0] = 32'hA5A50001; wr_buf[1] = 32'h5A5A0002;
        apply_stimulus(32'hFC, 2, 1'b1, 1'b0, -1);
        apply_stimulus(32'hFC, 1, 1'b0, 1'b0, -1);
        check_output("wrap_last_word", rd_buf[0], 32'hA5A50001);
        apply_stimulus(32'h00, 1, 1'b0, 1'b0, -1);
        check_output("wrap_word_0", rd_buf[0], 32'h5A5A0002);
        apply_stimulus(32'h100, 1, 1'b0, 1'b0, -1);
        check_output("upper_bits_ignored", rd_buf[0], 32'h5A5A0002);

        $display("[TB] master abort mid write burst");
        wr_buf[0] = 32'hC0C0C0C0; wr_buf[1] = 32'hC1C1C1C1; wr_buf[2] = 32'hC2C2C2C2;
        apply_stimulus(32'h80, 3, 1'b1, 1'b0, -1);
        wr_buf[0] = 32'hD0D0D0D0; wr_buf[1] = 32'hD1D1D1D1; wr_buf[2] = 32'hD2D2D2D2; wr_buf[3] = 32'hD3D3D3D3;
        apply_stimulus(32'h80, 4, 1'b1, 1'b0, 2);
        apply_stimulus(32'h88, 1, 1'b0, 1'b0, -1);
        check_output("abort_next_wait", 32'(wait_buf[0]), 32'd1);
        check_output("abort_beat3_kept", rd_buf[0], 32'hC2C2C2C2);
        apply_stimulus(32'h80, 2, 1'b0, 1'b0, -1);
        check_output("abort_beat1", rd_buf[0], 32'hD0D0D0D0);
        check_output("abort_beat2", rd_buf[1], 32'hD1D1D1D1);

        $display("[TB] reset mid burst");
        wr_buf[0] = 32'hE0E0E0E0; wr_buf[1] = 32'hE1E1E1E1;
        apply_stimulus(32'hA0, 2, 1'b1, 1'b0, -1);
        begin
            int waited;
            bit ok;
            @(posedge clk);
            #1;
            adr = 32'hA0; dat_i = 32'hF0F0F0F0; we = 1'b1; cti = 3'b010;
            cyc = 1'b1; stb = 1'b1; cur_word = 40; cur_beat = 0;
            wait_ack(waited, ok);
            @(posedge clk);
            #1;
            adr = 32'hA4; dat_i = 32'hF1F1F1F1; cti = 3'b111; cur_word = 41;
            #1 check_output("reset_pre_ack", {31'b0, ack}, {31'b0, BURST_ACK});
            #1 rst_n = 1'b0;
            #1 check_output("reset_ack_drop", {31'b0, ack}, 32'h0);
            go_idle();
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check_output("reset_dat_cleared", dat_o, 32'h0);
        end
        apply_stimulus(32'hA0, 1, 1'b0, 1'b0, -1);
        check_output("reset_beat1_kept", rd_buf[0], 32'hF0F0F0F0);
        apply_stimulus(32'hA4, 1, 1'b0, 1'b0, -1);
        check_output("reset_beat2_dropped", rd_buf[0], 32'hE1E1E1E1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
